// File: rtl/rvvi_retire_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rvvi_retire_fifo
// Purpose  : Multi-lane retirement-record FIFO with registered first-word-
//            fall-through output and a sticky retirement-order checker.
//            Up to NRET records are accepted per cycle. Valid lanes are
//            compacted into consecutive tail slots. One record is popped
//            per cycle.
// Ports    : clk_i, reset_i (async, active-high), flush_i (sync clear)
//            in_valid_i/in_order_i/in_insn_i/in_pc_i/in_trap_i/in_mode_i
//                  - lane-packed input records, lane l at [l*W +: W]
//            in_ready_o  - at least NRET free entries
//            out_valid_o/out_ready_i/out_*_o - head record handshake
//            count_o     - occupancy
//            order_err_o, err_expected_o, err_observed_o - first order break
// Revision : 1.0 - initial release
// ============================================================================
module rvvi_retire_fifo #(
    parameter int XLEN   = 64,
    parameter int NRET   = 2,
    parameter int DEPTH  = 8,
    parameter int ORDERW = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic [NRET-1:0]            in_valid_i,
    input  logic [NRET*ORDERW-1:0]     in_order_i,
    input  logic [NRET*32-1:0]         in_insn_i,
    input  logic [NRET*XLEN-1:0]       in_pc_i,
    input  logic [NRET-1:0]            in_trap_i,
    input  logic [NRET*2-1:0]          in_mode_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ORDERW-1:0]          out_order_o,
    output logic [31:0]                out_insn_o,
    output logic [XLEN-1:0]            out_pc_o,
    output logic                       out_trap_o,
    output logic [1:0]                 out_mode_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       order_err_o,
    output logic [ORDERW-1:0]          err_expected_o,
    output logic [ORDERW-1:0]          err_observed_o
);

    localparam int C_PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNTW = $clog2(DEPTH) + 1;
    localparam logic [C_CNTW-1:0] C_DEPTH = C_CNTW'(DEPTH);
    localparam logic [C_CNTW-1:0] C_NRET  = C_CNTW'(NRET);

    // Storage (not reset: contents are don't-care while empty)
    logic [ORDERW-1:0] mem_order_q [DEPTH];
    logic [31:0]       mem_insn_q  [DEPTH];
    logic [XLEN-1:0]   mem_pc_q    [DEPTH];
    logic              mem_trap_q  [DEPTH];
    logic [1:0]        mem_mode_q  [DEPTH];

    logic [C_PTRW-1:0] head_q, head_d;
    logic [C_PTRW-1:0] tail_q, tail_d;
    logic [C_CNTW-1:0] count_q, count_d;

    logic              armed_q;
    logic [ORDERW-1:0] expected_q;
    logic              order_err_q;
    logic [ORDERW-1:0] err_expected_q;
    logic [ORDERW-1:0] err_observed_q;

    logic              w_push;
    logic              w_pop;
    logic [C_CNTW-1:0] w_free;
    logic [C_CNTW-1:0] w_push_cnt;
    logic [C_CNTW-1:0] w_off  [NRET];
    logic [C_PTRW-1:0] w_slot [NRET];

    // in_ready depends only on registered occupancy, never on out_ready.
    assign w_free      = C_DEPTH - count_q;
    assign in_ready_o  = (w_free >= C_NRET);
    assign out_valid_o = (count_q != '0);

    assign w_push = in_ready_o  & ~flush_i;
    assign w_pop  = out_valid_o & out_ready_i & ~flush_i;

    // Compaction: each valid lane lands at tail + (number of valid lanes
    // below it), so gaps in the valid pattern never leave holes.
    always_comb begin
        w_push_cnt = '0;
        for (int l = 0; l < NRET; l++) begin
            w_off[l]  = w_push_cnt;
            w_slot[l] = C_PTRW'((32'(tail_q) + 32'(w_push_cnt)) % DEPTH);
            if (in_valid_i[l]) begin
                w_push_cnt = w_push_cnt + C_CNTW'(1);
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_push) begin
            tail_d  = C_PTRW'((32'(tail_q) + 32'(w_push_cnt)) % DEPTH);
            count_d = count_d + w_push_cnt;
        end
        if (w_pop) begin
            head_d  = C_PTRW'((32'(head_q) + 32'd1) % DEPTH);
            count_d = count_d - C_CNTW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            for (int l = 0; l < NRET; l++) begin
                if (in_valid_i[l]) begin
                    mem_order_q[w_slot[l]] <= in_order_i[l*ORDERW +: ORDERW];
                    mem_insn_q[w_slot[l]]  <= in_insn_i[l*32 +: 32];
                    mem_pc_q[w_slot[l]]    <= in_pc_i[l*XLEN +: XLEN];
                    mem_trap_q[w_slot[l]]  <= in_trap_i[l];
                    mem_mode_q[w_slot[l]]  <= in_mode_i[l*2 +: 2];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Order checker. The first pop after reset/flush only seeds the
    // expectation; order_err and its capture survive flush.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            armed_q        <= 1'b0;
            expected_q     <= '0;
            order_err_q    <= 1'b0;
            err_expected_q <= '0;
            err_observed_q <= '0;
        end else if (flush_i) begin
            armed_q <= 1'b0;
        end else if (w_pop) begin
            armed_q    <= 1'b1;
            expected_q <= out_order_o + ORDERW'(1);
            if (armed_q && (out_order_o != expected_q) && !order_err_q) begin
                order_err_q    <= 1'b1;
                err_expected_q <= expected_q;
                err_observed_q <= out_order_o;
            end
        end
    end

    assign out_order_o    = mem_order_q[head_q];
    assign out_insn_o     = mem_insn_q[head_q];
    assign out_pc_o       = mem_pc_q[head_q];
    assign out_trap_o     = mem_trap_q[head_q];
    assign out_mode_o     = mem_mode_q[head_q];
    assign count_o        = count_q;
    assign order_err_o    = order_err_q;
    assign err_expected_o = err_expected_q;
    assign err_observed_o = err_observed_q;

endmodule
`default_nettype wire

// File: tb/tb_rvvi_retire_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvvi_retire_fifo
// Purpose  : Directed self-checking bench for rvvi_retire_fifo with
//            NRET=2, DEPTH=8, XLEN=64, ORDERW=64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvvi_retire_fifo;

    localparam int XLEN   = 64;
    localparam int NRET   = 2;
    localparam int DEPTH  = 8;
    localparam int ORDERW = 64;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic [NRET-1:0]        in_valid;
    logic [NRET*ORDERW-1:0] in_order;
    logic [NRET*32-1:0]     in_insn;
    logic [NRET*XLEN-1:0]   in_pc;
    logic [NRET-1:0]        in_trap;
    logic [NRET*2-1:0]      in_mode;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [ORDERW-1:0]      out_order;
    logic [31:0]            out_insn;
    logic [XLEN-1:0]        out_pc;
    logic                   out_trap;
    logic [1:0]             out_mode;
    logic [3:0]             count;
    logic                   order_err;
    logic [ORDERW-1:0]      err_expected;
    logic [ORDERW-1:0]      err_observed;

    int n_checks = 0;
    int n_errors = 0;

    rvvi_retire_fifo #(
        .XLEN   (XLEN),
        .NRET   (NRET),
        .DEPTH  (DEPTH),
        .ORDERW (ORDERW)
    ) u_dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_order_i     (in_order),
        .in_insn_i      (in_insn),
        .in_pc_i        (in_pc),
        .in_trap_i      (in_trap),
        .in_mode_i      (in_mode),
        .in_ready_o     (in_ready),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_order_o    (out_order),
        .out_insn_o     (out_insn),
        .out_pc_o       (out_pc),
        .out_trap_o     (out_trap),
        .out_mode_o     (out_mode),
        .count_o        (count),
        .order_err_o    (order_err),
        .err_expected_o (err_expected),
        .err_observed_o (err_observed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Record fields are derived from the order number so each popped
    // record can be fully predicted.
    function automatic logic [63:0] pc_of(input logic [63:0] o);
        return 64'h0000_0000_8000_0000 + (o << 2);
    endfunction

    function automatic logic [31:0] insn_of(input logic [63:0] o);
        return {o[19:0], 12'h013};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
        in_valid = v;
        in_order = {o1, o0};
        in_pc    = {pc_of(o1), pc_of(o0)};
        in_insn  = {insn_of(o1), insn_of(o0)};
        in_trap  = {o1[0], o0[0]};
        in_mode  = {o1[1:0], o0[1:0]};
    endtask

    // Check the full head record, then pop it on the next edge.
    task automatic pop_check(input logic [63:0] o);
        check_val("pop_valid", {63'd0, out_valid}, 64'd1);
        check_val("pop_order", out_order, o);
        check_val("pop_pc", out_pc, pc_of(o));
        check_val("pop_insn", {32'd0, out_insn}, {32'd0, insn_of(o)});
        check_val("pop_trap", {63'd0, out_trap}, {63'd0, o[0]});
        check_val("pop_mode", {62'd0, out_mode}, {62'd0, o[1:0]});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_lanes(2'b00, 64'd0, 64'd0);

        // Reset state
        #2;
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("rst_count", {60'd0, count}, 64'd0);
        check_val("rst_order_err", {63'd0, order_err}, 64'd0);
        check_val("rst_err_exp", err_expected, 64'd0);
        check_val("rst_err_obs", err_observed, 64'd0);
        tick();
        reset = 1'b0;

        // Two-lane push, drained back-to-back
        set_lanes(2'b11, 64'd5, 64'd6);
        out_ready = 1'b1;
        tick();
        set_lanes(2'b00, 64'd0, 64'd0);
        check_val("p56_count", {60'd0, count}, 64'd2);
        pop_check(64'd5);
        pop_check(64'd6);
        check_val("p56_empty", {63'd0, out_valid}, 64'd0);

        // Only lane 1 valid: compacts into the first free slot
        set_lanes(2'b10, 64'd99, 64'd7);
        tick();
        set_lanes(2'b00, 64'd0, 64'd0);
        check_val("l1_count", {60'd0, count}, 64'd1);
        pop_check(64'd7);
        check_val("l1_empty", {63'd0, out_valid}, 64'd0);

        // Fill to full, check backpressure and head stability
        for (int k = 0; k < 4; k++) begin
            set_lanes(2'b11, 64'(8 + 2*k), 64'(9 + 2*k));
            tick();
        end
        set_lanes(2'b00, 64'd0, 64'd0);
        check_val("full_count", {60'd0, count}, 64'd8);
        check_val("full_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        check_val("stall_order", out_order, 64'd8);
        set_lanes(2'b11, 64'd99, 64'd98);   // must be ignored while not ready
        pop_check(64'd8);
        set_lanes(2'b00, 64'd0, 64'd0);
        check_val("pop1_count", {60'd0, count}, 64'd7);
        check_val("pop1_in_ready", {63'd0, in_ready}, 64'd0);
        pop_check(64'd9);
        check_val("pop2_count", {60'd0, count}, 64'd6);
        check_val("pop2_in_ready", {63'd0, in_ready}, 64'd1);
        set_lanes(2'b11, 64'd16, 64'd17);   // push and pop together
        pop_check(64'd10);
        set_lanes(2'b00, 64'd0, 64'd0);
        check_val("pushpop_count", {60'd0, count}, 64'd7);
        for (int k = 11; k <= 17; k++) begin
            pop_check(64'(k));
        end
        check_val("drain_count", {60'd0, count}, 64'd0);
        check_val("drain_valid", {63'd0, out_valid}, 64'd0);
        check_val("drain_err", {63'd0, order_err}, 64'd0);

        // Flush discards contents and suppresses a same-cycle push
        set_lanes(2'b01, 64'd40, 64'd0);
        tick();
        set_lanes(2'b11, 64'd50, 64'd51);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_lanes(2'b00, 64'd0, 64'd0);
        check_val("flush_count", {60'd0, count}, 64'd0);
        check_val("flush_valid", {63'd0, out_valid}, 64'd0);
        check_val("flush_in_ready", {63'd0, in_ready}, 64'd1);

        // Order discontinuity: 10, 12, 13, 20
        set_lanes(2'b11, 64'd10, 64'd12);
        tick();
        set_lanes(2'b11, 64'd13, 64'd20);
        tick();
        set_lanes(2'b00, 64'd0, 64'd0);
        check_val("gap_count", {60'd0, count}, 64'd4);
        pop_check(64'd10);
        check_val("arm_no_err", {63'd0, order_err}, 64'd0);
        pop_check(64'd12);
        check_val("gap_err", {63'd0, order_err}, 64'd1);
        check_val("gap_exp", err_expected, 64'd11);
        check_val("gap_obs", err_observed, 64'd12);
        pop_check(64'd13);
        pop_check(64'd20);
        check_val("sticky_err", {63'd0, order_err}, 64'd1);
        check_val("sticky_exp", err_expected, 64'd11);
        check_val("sticky_obs", err_observed, 64'd12);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("flush_keeps_err", {63'd0, order_err}, 64'd1);

        // Asynchronous reset in mid-operation
        set_lanes(2'b11, 64'd30, 64'd31);
        tick();
        set_lanes(2'b11, 64'd32, 64'd33);
        tick();
        set_lanes(2'b01, 64'd34, 64'd0);
        tick();
        set_lanes(2'b00, 64'd0, 64'd0);
        check_val("pre_rst_count", {60'd0, count}, 64'd5);
        #3;
        reset = 1'b1;
        #1;
        check_val("async_count", {60'd0, count}, 64'd0);
        check_val("async_valid", {63'd0, out_valid}, 64'd0);
        check_val("async_err", {63'd0, order_err}, 64'd0);
        check_val("async_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        reset = 1'b0;

        // Disarmed checker after reset, and all-ones -> 0 wrap is legal
        set_lanes(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        tick();
        set_lanes(2'b00, 64'd0, 64'd0);
        check_val("wrap_count", {60'd0, count}, 64'd2);
        pop_check(64'hFFFF_FFFF_FFFF_FFFF);
        pop_check(64'd0);
        check_val("wrap_err", {63'd0, order_err}, 64'd0);
        check_val("wrap_empty", {60'd0, count}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
